imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer in front of the single-cycle core's instruction ROM. It owns the program counter and drives the ROM's word address and read strobe. It captures the ROM's registered output into a small instruction buffer and presents instructions to decode over a valid/ready handshake. It also handles branch/jump redirects, backpressure and fetch faults (misaligned or out-of-range PC).

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
IMEM_WORDS, 32, ROM depth in 32-bit words; word index >= IMEM_WORDS is out of range
BUF_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
mem_addr  out  32  ROM word index (pc >> 2)
mem_rd  out  1  ROM read strobe; ROM data valid on mem_data the cycle after
mem_data  in  32  ROM instruction word
redirect_valid  in  1  load new PC (branch/jump taken)
redirect_pc  in  32  redirect byte address
out_valid  out  1  buffer head holds an instruction
out_ready  in  1  decode accepts the head
out_instr  out  32  head instruction
out_pc  out  32  byte PC of head instruction
fault  out  1  fetch fault sticky flag
fault_cause  out  2  01 misaligned, 10 out of range, 00 none

Behaviour:
- Reset (async, any cycle): pc=RESET_PC, state=IDLE, mem_rd=0, mem_addr=0, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_cause=00. Buffer and in-flight count cleared, epoch=0.
- FSM states: IDLE, RUN, FAULT.
- IDLE->RUN on the first clock edge after RST deasserts; no read issued in IDLE.
- ROM latency is 1 cycle. A read issued in cycle N (mem_rd=1, mem_addr=pc>>2) has data on mem_data in N+1. The data is written to the buffer at the end of N+1 and is visible as out_valid in N+2.
- Earliest first out_valid: 3rd cycle after RST deassertion, with out_pc=RESET_PC.
- Credit rule: credit = buffer count + in-flight reads (0 or 1).
  - Issue a read in RUN when credit < BUF_DEPTH.
  - Also issue when credit == BUF_DEPTH and a pop (out_valid & out_ready) occurs in the same cycle.
  - On each issue, pc += 4.
  - Steady-state throughput is 1 instruction/cycle when out_ready is held high.
- Buffer is a FIFO. Pop happens on out_valid & out_ready. Push and pop in the same cycle are both legal when full or empty. out_instr and out_pc hold stable while out_valid=1 and out_ready=0.
- Each buffer entry stores {instr, pc}. The pc stored is the one used for that read.
- Redirect (redirect_valid=1 in RUN):
  - Buffer is flushed at that edge; out_valid=0 the next cycle.
  - epoch toggles; a response returning with the old epoch is dropped.
  - pc=redirect_pc. No read is issued in the redirect cycle; the first read of the new stream is issued the next cycle.
  - A redirect takes priority over a same-cycle pop and issue (the pop is discarded).
- Fault checks apply to the PC about to be issued:
  - pc[1:0]!=0 sets fault_cause=01.
  - (pc>>2) >= IMEM_WORDS sets fault_cause=10.
  - On either fault: no read is issued, fault=1, state->FAULT.
  - Instructions already buffered still drain to decode.
- FAULT:
  - mem_rd=0.
  - A redirect with a legal PC clears fault and fault_cause, then goes to RUN with normal redirect semantics.
  - A redirect with an illegal PC stays in FAULT with the cause updated.
  - RST clears from any state.
- mem_addr holds its last value when mem_rd=0.

Optional Feature:
FETCH_PERF_CNT_EN:
- When defined, adds outputs perf_fetched (32) and perf_stall (32).
  - perf_fetched counts pops.
  - perf_stall counts cycles with out_valid=1 & out_ready=0.
  - Both wrap at 2^32, reset to 0 by RST, and freeze in FAULT.
- When undefined, neither port nor counters exist; the core logic is identical.

Test Plan:
- Reset release, out_ready=1 -> mem_addr 0,1,2,... on consecutive cycles; out_valid from cycle 3; out_pc 0,4,8 and out_instr 32'h01234567, 32'h89ABCDEF, 32'hAABBCCDD with no bubbles.
- Hold out_ready=0 for 5 cycles after the first valid -> at most BUF_DEPTH entries buffered; mem_rd=0 once credit is full; out_pc held at 0; on release, pc 4,8 follow with no loss or duplicate.
- Redirect to 32'h20 in a cycle where a read is in flight -> stale data is dropped; the next out_pc is 32'h20 with instr 32'h55555555 (word 8).
- Redirect to 32'h7E -> fault=1, fault_cause=01, mem_rd=0; a later redirect to 32'h10 -> fault=0, out_pc=32'h10, instr 32'h12345678.
- Sequential fetch reaching pc 32'h80 -> fault_cause=10 after word 31 (32'hDEADCAFE) is delivered; no read of word 32.
- Assert RST mid-stream with a full buffer -> out_valid=0 and mem_rd=0 immediately (async); restart from RESET_PC. With FETCH_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/imem_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl_if
//
// Bundles the ROM port, the redirect request, the decode handshake and the
// fault status of the instruction-fetch sequencer.
//
//   mem_addr       ROM word index (pc >> 2)
//   mem_rd         ROM read strobe; data returns on mem_data one cycle later
//   mem_data       ROM instruction word
//   redirect_valid load a new PC (taken branch / jump)
//   redirect_pc    redirect byte address
//   out_valid      buffer head holds an instruction
//   out_ready      decode accepts the head
//   out_instr      head instruction
//   out_pc         byte PC of the head instruction
//   fault          sticky fetch-fault flag
//   fault_cause    01 misaligned, 10 out of range, 00 none
//
// Modports:
//   master - the fetch sequencer
//   slave  - the surrounding ROM / decode / branch logic
// ---------------------------------------------------------------------------
interface imem_fetch_ctrl_if;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [1:0]  fault_cause;

  modport master (
    output mem_addr, mem_rd, out_valid, out_instr, out_pc, fault, fault_cause,
    input  mem_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  mem_addr, mem_rd, out_valid, out_instr, out_pc, fault, fault_cause,
    output mem_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction-fetch sequencer in front of the instruction ROM. Owns the PC,
// issues ROM reads under a credit scheme, captures returning words into a
// small FIFO and hands them to decode over valid/ready. Handles redirects
// (branch/jump), backpressure and fetch faults (misaligned / out-of-range PC).
//
// Ports:
//   CLK           clock, rising edge
//   RST           asynchronous, active-high reset
//   bus           imem_fetch_ctrl_if.master (ROM port, redirect, decode
//                 handshake, fault status)
//   perf_fetched  (FETCH_PERF_CNT_EN only) count of instructions popped
//   perf_stall    (FETCH_PERF_CNT_EN only) cycles with out_valid & !out_ready
//
// Parameters:
//   RESET_PC    byte address fetched first after reset
//   IMEM_WORDS  ROM depth in 32-bit words
//   BUF_DEPTH   instruction buffer entries (power of 2, >= 2)
//
// Optional build macro: FETCH_PERF_CNT_EN adds the two performance counters.
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  imem_fetch_ctrl_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam int          PW           = $clog2(BUF_DEPTH);
  localparam int          CW           = PW + 1;
  localparam logic [CW:0] DEPTH_C      = (CW+1)'(BUF_DEPTH);
  localparam logic [31:0] IMEM_WORDS_W = 32'(IMEM_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [31:0]     pc_reg, pc_next;
  logic [31:0]     mem_addr_reg, mem_addr_next;
  logic            epoch_reg, epoch_next;
  logic            inflight_reg, inflight_next;
  logic            inflight_epoch_reg, inflight_epoch_next;
  logic [31:0]     inflight_pc_reg, inflight_pc_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            fault_reg, fault_next;
  logic [1:0]      cause_reg, cause_next;

  // Each entry is {instr, pc}. Read combinationally so the head is visible
  // the cycle after it is written.
  logic [63:0]     fifo_mem [BUF_DEPTH];
  logic [63:0]     head_entry;

  logic            redirect_take;
  logic            head_valid;
  logic            pop;
  logic            push;
  logic            issue;
  logic            credit_ok;
  logic [CW:0]     credit;
  logic [1:0]      pc_cause;
  logic [1:0]      redir_cause;
  logic [31:0]     pc_word;

  // 01 = misaligned, 10 = word index beyond the ROM, 00 = legal.
  function automatic logic [1:0] check_pc(input logic [31:0] p);
    if (p[1:0] != 2'b00) begin
      return 2'b01;
    end
    if ({2'b00, p[31:2]} >= IMEM_WORDS_W) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  assign pc_cause    = check_pc(pc_reg);
  assign redir_cause = check_pc(bus.redirect_pc);
  assign pc_word     = {2'b00, pc_reg[31:2]};

  assign head_valid    = (count_reg != '0);
  assign redirect_take = bus.redirect_valid && ((state_reg == RUN) || (state_reg == FAULT));
  // A redirect discards the head, so a same-cycle handshake does not count.
  assign pop           = head_valid && bus.out_ready && !redirect_take;
  // Responses from before the last redirect carry the old epoch and are
  // dropped; a response landing in the redirect cycle itself is flushed.
  assign push          = inflight_reg && (inflight_epoch_reg == epoch_reg) && !redirect_take;

  // Outstanding commitments: buffered entries plus the read in flight.
  // A full credit still allows an issue when a slot frees up this cycle,
  // which is what sustains one instruction per cycle.
  assign credit    = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
  assign credit_ok = (credit < DEPTH_C) || ((credit == DEPTH_C) && pop);

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state, PC, epoch and fault logic
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    epoch_next = epoch_reg;
    fault_next = fault_reg;
    cause_next = cause_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        state_next = RUN;
      end
      RUN: begin
        if (redirect_take) begin
          // No read in the redirect cycle; the new stream starts next cycle.
          pc_next    = bus.redirect_pc;
          epoch_next = ~epoch_reg;
        end else if (credit_ok) begin
          if (pc_cause == 2'b00) begin
            issue   = 1'b1;
            pc_next = pc_reg + 32'd4;
          end else begin
            fault_next = 1'b1;
            cause_next = pc_cause;
            state_next = FAULT;
          end
        end
      end
      FAULT: begin
        if (redirect_take) begin
          pc_next    = bus.redirect_pc;
          epoch_next = ~epoch_reg;
          cause_next = redir_cause;
          if (redir_cause == 2'b00) begin
            fault_next = 1'b0;
            state_next = RUN;
          end else begin
            fault_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Read tracking and FIFO bookkeeping
  always_comb begin
    mem_addr_next       = mem_addr_reg;
    inflight_next       = issue;
    inflight_pc_next    = inflight_pc_reg;
    inflight_epoch_next = inflight_epoch_reg;
    wr_ptr_next         = wr_ptr_reg;
    rd_ptr_next         = rd_ptr_reg;
    count_next          = count_reg;

    if (issue) begin
      mem_addr_next       = pc_word;
      inflight_pc_next    = pc_reg;
      inflight_epoch_next = epoch_reg;
    end

    if (redirect_take) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_reg             <= RESET_PC;
      mem_addr_reg       <= '0;
      epoch_reg          <= 1'b0;
      inflight_reg       <= 1'b0;
      inflight_epoch_reg <= 1'b0;
      inflight_pc_reg    <= '0;
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      count_reg          <= '0;
      fault_reg          <= 1'b0;
      cause_reg          <= 2'b00;
    end else begin
      pc_reg             <= pc_next;
      mem_addr_reg       <= mem_addr_next;
      epoch_reg          <= epoch_next;
      inflight_reg       <= inflight_next;
      inflight_epoch_reg <= inflight_epoch_next;
      inflight_pc_reg    <= inflight_pc_next;
      wr_ptr_reg         <= wr_ptr_next;
      rd_ptr_reg         <= rd_ptr_next;
      count_reg          <= count_next;
      fault_reg          <= fault_next;
      cause_reg          <= cause_next;
    end
  end

  // Storage needs no reset: nothing is pushed while in reset, and the
  // outputs are masked whenever the buffer is empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {bus.mem_data, inflight_pc_reg};
    end
  end

  assign head_entry = fifo_mem[rd_ptr_reg];

  assign bus.mem_rd      = issue;
  assign bus.mem_addr    = issue ? pc_word : mem_addr_reg;
  assign bus.out_valid   = head_valid;
  assign bus.out_instr   = head_valid ? head_entry[63:32] : 32'h0;
  assign bus.out_pc      = head_valid ? head_entry[31:0]  : 32'h0;
  assign bus.fault       = fault_reg;
  assign bus.fault_cause = cause_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_stall_reg;

  // Both counters freeze while the fetcher sits in FAULT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_fetched_reg <= '0;
      perf_stall_reg   <= '0;
    end else if (state_reg != FAULT) begin
      if (pop) begin
        perf_fetched_reg <= perf_fetched_reg + 32'd1;
      end
      if (head_valid && !bus.out_ready) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_stall   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//
// Directed bench for imem_fetch_ctrl: reset state, streaming, backpressure,
// redirect with a stale response, misaligned fault and recovery, out-of-range
// fault at the end of the ROM, and asynchronous reset mid-stream.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] rom [32];

  imem_fetch_ctrl_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  imem_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_WORDS(32), .BUF_DEPTH(2)) dut (
    .CLK(clk), .RST(rst), .bus(bus),
    .perf_fetched(perf_fetched), .perf_stall(perf_stall)
  );
`else
  imem_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_WORDS(32), .BUF_DEPTH(2)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_rd(input logic [31:0] a);
    if (a < 32'd32) return rom[a[4:0]];
    return 32'hBAD0_BAD0;
  endfunction

  // One-cycle-latency ROM model
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= rom_rd(bus.mem_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Leaves the bench in the cycle where RST has just deasserted (cycle 0).
  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    step();
    step();
    sample();
    checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got %b want 0", bus.mem_rd); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h want 0", bus.out_instr); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %h want 0", bus.out_pc); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", bus.fault); end
    checks++; if (bus.fault_cause !== 2'b00) begin errors++; $display("FAIL reset_cause got %b want 00", bus.fault_cause); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_fetched !== 32'h0) begin errors++; $display("FAIL reset_perf_fetched got %0d want 0", perf_fetched); end
    checks++; if (perf_stall !== 32'h0) begin errors++; $display("FAIL reset_perf_stall got %0d want 0", perf_stall); end
`endif
    step();
    rst = 1'b0;
    sample();
    checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL idle_mem_rd got %b want 0", bus.mem_rd); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      step();
      sample();
      checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'(c - 1)) begin errors++; $display("FAIL stream_issue c%0d got rd=%b addr=%0d want rd=1 addr=%0d", c, bus.mem_rd, bus.mem_addr, c - 1); end
      if (c < 3) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid c%0d got %b want 0", c, bus.out_valid); end
      end else begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'((c - 3) * 4) || bus.out_instr !== rom[c - 3]) begin errors++; $display("FAIL stream_out c%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", c, bus.out_valid, bus.out_pc, bus.out_instr, 32'((c - 3) * 4), rom[c - 3]); end
      end
    end
    $display("test_stream done");
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    do_reset();
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c == 8) bus.out_ready = 1'b1;
      sample();
      if (c >= 3 && c <= 7) begin
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL bp_hold_rd c%0d got %b want 0", c, bus.mem_rd); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== rom[0]) begin errors++; $display("FAIL bp_hold_head c%0d got v=%b pc=%h instr=%h want v=1 pc=0 instr=%h", c, bus.out_valid, bus.out_pc, bus.out_instr, rom[0]); end
      end
      if (c >= 8) begin
        checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'(c - 6)) begin errors++; $display("FAIL bp_release_rd c%0d got rd=%b addr=%0d want rd=1 addr=%0d", c, bus.mem_rd, bus.mem_addr, c - 6); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'((c - 8) * 4) || bus.out_instr !== rom[c - 8]) begin errors++; $display("FAIL bp_release_out c%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", c, bus.out_valid, bus.out_pc, bus.out_instr, 32'((c - 8) * 4), rom[c - 8]); end
      end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_redirect();
    bus.out_ready = 1'b1;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      step();
      bus.redirect_valid = (c == 3);
      bus.redirect_pc = 32'h20;
      sample();
      if (c == 3) begin
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL redir_cycle_rd got %b want 0", bus.mem_rd); end
      end
      if (c == 4) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'd8) begin errors++; $display("FAIL redir_first_rd got rd=%b addr=%0d want rd=1 addr=8", bus.mem_rd, bus.mem_addr); end
      end
      if (c == 5) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL redir_stale_valid got %b want 0", bus.out_valid); end
      end
      if (c == 6) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h20 || bus.out_instr !== 32'h5555_5555) begin errors++; $display("FAIL redir_new_head got v=%b pc=%h instr=%h want v=1 pc=00000020 instr=55555555", bus.out_valid, bus.out_pc, bus.out_instr); end
      end
      if (c == 7) begin
        checks++; if (bus.out_pc !== 32'h24 || bus.out_instr !== rom[9]) begin errors++; $display("FAIL redir_second got pc=%h instr=%h want pc=00000024 instr=%h", bus.out_pc, bus.out_instr, rom[9]); end
      end
    end
    bus.redirect_valid = 1'b0;
    $display("test_redirect done");
  endtask

  task automatic test_misalign_fault();
    bus.out_ready = 1'b1;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      step();
      bus.redirect_valid = (c == 3) || (c == 6);
      bus.redirect_pc = (c == 3) ? 32'h7E : 32'h10;
      sample();
      if (c == 4) begin
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL misalign_no_rd got %b want 0", bus.mem_rd); end
      end
      if (c == 5) begin
        checks++; if (bus.fault !== 1'b1 || bus.fault_cause !== 2'b01) begin errors++; $display("FAIL misalign_fault got fault=%b cause=%b want 1 01", bus.fault, bus.fault_cause); end
        checks++; if (bus.mem_rd !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL misalign_idle got rd=%b v=%b want 0 0", bus.mem_rd, bus.out_valid); end
      end
      if (c == 7) begin
        checks++; if (bus.fault !== 1'b0 || bus.fault_cause !== 2'b00) begin errors++; $display("FAIL recover_clear got fault=%b cause=%b want 0 00", bus.fault, bus.fault_cause); end
        checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'd4) begin errors++; $display("FAIL recover_rd got rd=%b addr=%0d want rd=1 addr=4", bus.mem_rd, bus.mem_addr); end
      end
      if (c == 9) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h10 || bus.out_instr !== 32'h1234_5678) begin errors++; $display("FAIL recover_head got v=%b pc=%h instr=%h want v=1 pc=00000010 instr=12345678", bus.out_valid, bus.out_pc, bus.out_instr); end
      end
    end
    bus.redirect_valid = 1'b0;
    $display("test_misalign_fault done");
  endtask

  task automatic test_range_fault();
    bus.out_ready = 1'b1;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      step();
      bus.redirect_valid = (c == 3);
      bus.redirect_pc = 32'h70;
      sample();
      if (c == 7) begin
        checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'd31) begin errors++; $display("FAIL range_last_rd got rd=%b addr=%0d want rd=1 addr=31", bus.mem_rd, bus.mem_addr); end
      end
      if (c == 8) begin
        checks++; if (bus.out_pc !== 32'h78 || bus.fault !== 1'b0) begin errors++; $display("FAIL range_pre got pc=%h fault=%b want pc=00000078 fault=0", bus.out_pc, bus.fault); end
      end
      if (c == 9) begin
        checks++; if (bus.fault !== 1'b1 || bus.fault_cause !== 2'b10) begin errors++; $display("FAIL range_fault got fault=%b cause=%b want 1 10", bus.fault, bus.fault_cause); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h7C || bus.out_instr !== 32'hDEAD_CAFE) begin errors++; $display("FAIL range_drain got v=%b pc=%h instr=%h want v=1 pc=0000007c instr=deadcafe", bus.out_valid, bus.out_pc, bus.out_instr); end
      end
      if (c == 10) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL range_empty got %b want 0", bus.out_valid); end
      end
      if (c >= 8) begin
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL range_no_rd c%0d got rd=%b addr=%0d want rd=0", c, bus.mem_rd, bus.mem_addr); end
      end
    end
    bus.redirect_valid = 1'b0;
    $display("test_range_fault done");
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 8) bus.out_ready = 1'b1;
      sample();
    end
    checks++; if (bus.mem_rd !== 1'b1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got rd=%b v=%b want 1 1", bus.mem_rd, bus.out_valid); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_stall !== 32'd5 || perf_fetched !== 32'd0) begin errors++; $display("FAIL arst_pre_perf got stall=%0d fetched=%0d want 5 0", perf_stall, perf_fetched); end
`endif
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_rd !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_now got rd=%b v=%b want 0 0", bus.mem_rd, bus.out_valid); end
    checks++; if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin errors++; $display("FAIL arst_out got pc=%h instr=%h want 0 0", bus.out_pc, bus.out_instr); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_stall !== 32'd0 || perf_fetched !== 32'd0) begin errors++; $display("FAIL arst_perf got stall=%0d fetched=%0d want 0 0", perf_stall, perf_fetched); end
`endif
    step();
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      sample();
      if (c == 1) begin
        checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 32'd0) begin errors++; $display("FAIL arst_restart_rd got rd=%b addr=%0d want rd=1 addr=0", bus.mem_rd, bus.mem_addr); end
      end
      if (c == 3) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== rom[0]) begin errors++; $display("FAIL arst_restart_head got v=%b pc=%h instr=%h want v=1 pc=0 instr=%h", bus.out_valid, bus.out_pc, bus.out_instr, rom[0]); end
      end
    end
    $display("test_async_reset done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.mem_data = 32'h0;
    for (int i = 0; i < 32; i++) rom[i] = 32'hC0DE_0000 | 32'(i);
    rom[0]  = 32'h0123_4567;
    rom[1]  = 32'h89AB_CDEF;
    rom[2]  = 32'hAABB_CCDD;
    rom[4]  = 32'h1234_5678;
    rom[8]  = 32'h5555_5555;
    rom[31] = 32'hDEAD_CAFE;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign_fault();
    test_range_fault();
    test_async_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
